// File: rtl/clint_bus_arbiter.sv
// Round-robin arbiter that shares one CLINT slave port among N_MASTERS
// core data-bus requesters. One transaction is in flight at a time: a request
// is latched in IDLE, presented to the slave in BUSY until it answers or the
// timeout expires, and the result is returned to the winner in DONE.
module clint_bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_MASTERS-1:0]            m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_address,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]     m_rdata,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic                            s_valid,
    output logic [ADDR_W-1:0]               s_address,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_ready,
    output logic                            timeout_err,
    output logic                            busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int GW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT != 0);

    // Counter value seen in the last permitted BUSY cycle.
    localparam logic [CW-1:0] TO_LAST   = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    // Last grant starts at the highest index so master 0 is first in line.
    localparam logic [GW-1:0] LAST_INIT = GW'(N_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_last_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic [CW-1:0]       r_count;
    logic                r_timed_out;

    logic                w_found;
    logic [GW-1:0]       w_win;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [STRB_W-1:0]   w_sel_wstrb;
    logic                w_to_hit;

    // Round-robin scan: first requester at last_grant+1, +2, ... modulo N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!w_found && m_valid[i] &&
                    (i == ((int'(r_last_grant) + k) % N_MASTERS))) begin
                    w_found = 1'b1;
                    w_win   = GW'(i);
                end
            end
        end
    end

    // Mux the winning master's request fields for latching.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (GW'(i) == w_win) begin
                w_sel_addr  = m_address[i*ADDR_W +: ADDR_W];
                w_sel_wdata = m_wdata[i*DATA_W +: DATA_W];
                w_sel_wstrb = m_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and all state-derived outputs.
    always_comb begin
        w_next      = r_state;
        w_to_hit    = 1'b0;
        s_valid     = 1'b0;
        busy        = 1'b0;
        timeout_err = 1'b0;
        m_ready     = '0;
        m_rdata     = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_valid = 1'b1;
                busy    = 1'b1;
                // A slave answer in the final allowed cycle beats the timeout.
                if (s_ready) begin
                    w_next = ST_DONE;
                end else if (TO_EN && (r_count == TO_LAST)) begin
                    w_next   = ST_DONE;
                    w_to_hit = 1'b1;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                timeout_err = r_timed_out;
                w_next      = ST_IDLE;
                for (int i = 0; i < N_MASTERS; i++) begin
                    if (GW'(i) == r_grant) begin
                        m_ready[i]                   = 1'b1;
                        m_rdata[i*DATA_W +: DATA_W]  = r_rdata;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Grant, request copies, response capture and BUSY-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= '0;
            r_last_grant <= LAST_INIT;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_rdata      <= '0;
            r_count      <= '0;
            r_timed_out  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_win;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        r_wstrb     <= w_sel_wstrb;
                        r_count     <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (s_ready) begin
                        r_rdata     <= s_rdata;
                        r_timed_out <= 1'b0;
                    end else if (w_to_hit) begin
                        r_rdata     <= '0;
                        r_timed_out <= 1'b1;
                    end
                    // With no timeout configured the counter stays parked at 0.
                    if (TO_EN) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_last_grant <= r_grant;
                    r_count      <= '0;
                    r_timed_out  <= 1'b0;
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign s_address = r_addr;
    assign s_wdata   = r_wdata;
    assign s_wstrb   = r_wstrb;

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Bench for clint_bus_arbiter: directed scenarios followed by a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_clint_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              clk;
    logic              reset;
    logic [N-1:0]      m_valid;
    logic [N*AW-1:0]   m_address;
    logic [N*DW-1:0]   m_wdata;
    logic [N*DW/8-1:0] m_wstrb;
    logic [N*DW-1:0]   m_rdata;
    logic [N-1:0]      m_ready;
    logic              s_valid;
    logic [AW-1:0]     s_address;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wstrb;
    logic [DW-1:0]     s_rdata;
    logic              s_ready;
    logic              timeout_err;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    clint_bus_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
        .s_valid(s_valid), .s_address(s_address), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
        .timeout_err(timeout_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid got=%0h exp=0", s_valid); end
        checks++; if (s_address !== '0) begin failures++; $display("FAIL reset_s_address got=%0h exp=0", s_address); end
        checks++; if (s_wdata !== '0) begin failures++; $display("FAIL reset_s_wdata got=%0h exp=0", s_wdata); end
        checks++; if (s_wstrb !== '0) begin failures++; $display("FAIL reset_s_wstrb got=%0h exp=0", s_wstrb); end
        checks++; if (m_ready !== '0) begin failures++; $display("FAIL reset_m_ready got=%0h exp=0", m_ready); end
        checks++; if (m_rdata !== '0) begin failures++; $display("FAIL reset_m_rdata got=%0h exp=0", m_rdata); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%0h exp=0", timeout_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_fairness();
        logic [31:0] rd;
        int exp;
        m_address = {32'h0000_0200, 32'h0000_0100};
        m_valid   = 2'b11;
        s_ready   = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp = j % 2;
            rd = $urandom;
            s_rdata = rd;
            @(negedge clk);
            checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL fair_s_valid txn=%0d got=%0h exp=1", j, s_valid); end
            checks++; if (s_address !== ((exp == 1) ? 32'h200 : 32'h100)) begin failures++; $display("FAIL fair_grant txn=%0d got_addr=%0h exp_master=%0d", j, s_address, exp); end
            @(negedge clk);
            checks++; if (m_ready !== ((exp == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL fair_m_ready txn=%0d got=%0b exp_master=%0d", j, m_ready, exp); end
            checks++; if (m_rdata[exp*32 +: 32] !== rd) begin failures++; $display("FAIL fair_m_rdata txn=%0d got=%0h exp=%0h", j, m_rdata[exp*32 +: 32], rd); end
            @(negedge clk);
            checks++; if (m_ready !== 2'b00 || s_valid !== 1'b0) begin failures++; $display("FAIL fair_gap txn=%0d got_ready=%0b got_svalid=%0b exp=0", j, m_ready, s_valid); end
            if (j == 3) m_valid = 2'b00;
        end
        s_ready = 1'b0;
    endtask

    task automatic test_single_read();
        m_address[31:0] = 32'h0200_BFF8;
        m_valid = 2'b01;
        s_ready = 1'b0;
        @(negedge clk);
        checks++; if (s_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL read_s_valid got=%0b busy=%0b exp=1", s_valid, busy); end
        checks++; if (s_address !== 32'h0200_BFF8) begin failures++; $display("FAIL read_s_address got=%0h exp=0200bff8", s_address); end
        checks++; if (m_ready !== 2'b00) begin failures++; $display("FAIL read_early_ready got=%0b exp=00", m_ready); end
        s_ready = 1'b1;
        s_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (m_ready !== 2'b01) begin failures++; $display("FAIL read_m_ready got=%0b exp=01", m_ready); end
        checks++; if (m_rdata !== {32'h0, 32'h1234_5678}) begin failures++; $display("FAIL read_m_rdata got=%0h exp=12345678", m_rdata); end
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL read_done_s_valid got=%0b exp=0", s_valid); end
        m_valid = 2'b00;
        s_ready = 1'b0;
        @(negedge clk);
        checks++; if (m_ready !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL read_idle got_ready=%0b busy=%0b exp=0", m_ready, busy); end
    endtask

    task automatic test_timeout();
        m_address[31:0] = 32'h0200_4000;
        m_valid = 2'b01;
        s_ready = 1'b0;
        s_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            checks++; if (s_valid !== 1'b1 || timeout_err !== 1'b0 || m_ready !== 2'b00) begin failures++; $display("FAIL to_busy cyc=%0d got_sv=%0b got_te=%0b got_mr=%0b exp=1,0,00", c, s_valid, timeout_err, m_ready); end
        end
        @(negedge clk);
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL to_s_valid_len got=%0b exp=0", s_valid); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_pulse got=%0b exp=1", timeout_err); end
        checks++; if (m_ready !== 2'b01) begin failures++; $display("FAIL to_m_ready got=%0b exp=01", m_ready); end
        checks++; if (m_rdata !== '0) begin failures++; $display("FAIL to_m_rdata got=%0h exp=0", m_rdata); end
        m_valid = 2'b00;
        @(negedge clk);
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL to_after got_te=%0b busy=%0b exp=0", timeout_err, busy); end
        m_valid = 2'b01;
        @(negedge clk);
        checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL to_next_s_valid got=%0b exp=1", s_valid); end
        s_ready = 1'b1;
        s_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (m_ready !== 2'b01 || m_rdata[31:0] !== 32'hCAFE_F00D || timeout_err !== 1'b0) begin failures++; $display("FAIL to_next_txn got_mr=%0b rd=%0h te=%0b exp=01,cafef00d,0", m_ready, m_rdata[31:0], timeout_err); end
        m_valid = 2'b00;
        s_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        m_address[63:32] = 32'h0200_4004;
        m_wdata[63:32]   = 32'hDEAD_BEEF;
        m_wstrb[7:4]     = 4'hF;
        m_valid = 2'b10;
        s_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (s_valid !== 1'b1 || m_ready !== 2'b00) begin failures++; $display("FAIL wr_busy cyc=%0d got_sv=%0b mr=%0b exp=1,00", c, s_valid, m_ready); end
            checks++; if (s_address !== 32'h0200_4004) begin failures++; $display("FAIL wr_s_address cyc=%0d got=%0h exp=02004004", c, s_address); end
            checks++; if (s_wdata !== 32'hDEAD_BEEF || s_wstrb !== 4'hF) begin failures++; $display("FAIL wr_s_data cyc=%0d got=%0h/%0h exp=deadbeef/f", c, s_wdata, s_wstrb); end
            if (c == 0) begin
                m_address[63:32] = $urandom;
                m_wdata[63:32]   = $urandom;
                m_wstrb[7:4]     = 4'h0;
            end
            if (c == 2) begin
                s_ready = 1'b1;
                s_rdata = 32'h0000_1111;
            end
        end
        @(negedge clk);
        checks++; if (m_ready !== 2'b10) begin failures++; $display("FAIL wr_m_ready got=%0b exp=10", m_ready); end
        m_valid = 2'b00;
        s_ready = 1'b0;
        @(negedge clk);
        checks++; if (m_ready !== 2'b00) begin failures++; $display("FAIL wr_single_pulse got=%0b exp=00", m_ready); end
    endtask

    task automatic test_late_ready();
        m_address[31:0] = 32'h0200_BFFC;
        m_valid = 2'b01;
        s_ready = 1'b0;
        s_rdata = 32'h0;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL late_busy cyc=%0d got=%0b exp=1", c, s_valid); end
            if (c == TO - 1) begin
                s_ready = 1'b1;
                s_rdata = 32'h0000_00A5;
            end
        end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL late_no_timeout got=%0b exp=0", timeout_err); end
        checks++; if (m_ready !== 2'b01 || m_rdata[31:0] !== 32'hA5) begin failures++; $display("FAIL late_rdata got_mr=%0b rd=%0h exp=01,a5", m_ready, m_rdata[31:0]); end
        m_valid = 2'b00;
        s_ready = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL late_idle busy=%0b te=%0b exp=0", busy, timeout_err); end
    endtask

    task automatic test_reset_mid_busy();
        m_address = {32'h0000_0B00, 32'h0000_0A00};
        m_valid = 2'b10;
        s_ready = 1'b0;
        @(negedge clk);
        checks++; if (s_valid !== 1'b1 || s_address !== 32'h0B00) begin failures++; $display("FAIL rst_pre got_sv=%0b addr=%0h exp=1,b00", s_valid, s_address); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (s_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_abort got_sv=%0b busy=%0b exp=0", s_valid, busy); end
        checks++; if (m_ready !== 2'b00) begin failures++; $display("FAIL rst_no_ready got=%0b exp=00", m_ready); end
        reset = 1'b0;
        m_valid = 2'b11;
        @(negedge clk);
        checks++; if (s_valid !== 1'b1 || s_address !== 32'h0A00 || m_ready !== 2'b00) begin failures++; $display("FAIL rst_master0_wins got_sv=%0b addr=%0h mr=%0b exp=1,a00,00", s_valid, s_address, m_ready); end
        s_ready = 1'b1;
        s_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        checks++; if (m_ready !== 2'b01 || m_rdata !== {32'h0, 32'h5A5A_5A5A}) begin failures++; $display("FAIL rst_after_txn got_mr=%0b rd=%0h exp=01,5a5a5a5a", m_ready, m_rdata); end
        m_valid = 2'b00;
        s_ready = 1'b0;
        @(negedge clk);
    endtask

    // Randomized traffic: each master holds a request until served; the slave
    // answers with probability 1/4 per cycle. The model predicts each winner
    // from the round-robin rule, the per-transaction result and the timeout.
    task automatic test_random();
        logic [N-1:0]  req;
        logic [31:0]   ra [N];
        logic [31:0]   rw [N];
        logic [3:0]    rs [N];
        logic [N-1:0]  mv_prev;
        logic [N-1:0]  exp_mr;
        logic [N*DW-1:0] exp_vec;
        logic [31:0]   exp_rd;
        bit            idle_next, in_txn, pend, exp_to, exp_start;
        int            win, last_g, bcyc, ncomp, nto, idx;
        @(negedge clk);
        reset   = 1'b1;
        m_valid = '0;
        s_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        req = '0; mv_prev = '0; idle_next = 1'b1; in_txn = 1'b0; pend = 1'b0;
        exp_to = 1'b0; exp_rd = '0; win = 0; last_g = N - 1; bcyc = 0; ncomp = 0; nto = 0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rw[i] = '0; rs[i] = '0; end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            exp_start = idle_next && (mv_prev != '0);
            s_ready = ($urandom_range(0, 1) == 1);
            s_rdata = $urandom;
            if (pend) begin
                exp_mr = '0;
                exp_mr[win] = 1'b1;
                exp_vec = '0;
                exp_vec[win*DW +: DW] = exp_rd;
                checks++; if (m_ready !== exp_mr) begin failures++; $display("FAIL rnd_m_ready cyc=%0d got=%0b exp=%0b", cyc, m_ready, exp_mr); end
                checks++; if (m_rdata !== exp_vec) begin failures++; $display("FAIL rnd_m_rdata cyc=%0d got=%0h exp=%0h", cyc, m_rdata, exp_vec); end
                checks++; if (timeout_err !== exp_to) begin failures++; $display("FAIL rnd_timeout_err cyc=%0d got=%0b exp=%0b", cyc, timeout_err, exp_to); end
                checks++; if (s_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rnd_done_flags cyc=%0d got_sv=%0b busy=%0b exp=0,1", cyc, s_valid, busy); end
                last_g = win;
                req[win] = 1'b0;
                pend = 1'b0;
                in_txn = 1'b0;
                idle_next = 1'b0;
                ncomp++;
                if (exp_to) nto++;
            end else begin
                if (!in_txn) begin
                    checks++; if (s_valid !== exp_start) begin failures++; $display("FAIL rnd_start cyc=%0d got=%0b exp=%0b", cyc, s_valid, exp_start); end
                    if (exp_start) begin
                        win = -1;
                        for (int k = 1; k <= N; k++) begin
                            idx = (last_g + k) % N;
                            if (win < 0 && mv_prev[idx]) win = idx;
                        end
                        in_txn = 1'b1;
                        bcyc = 0;
                    end else begin
                        checks++; if (busy !== 1'b0 || m_ready !== '0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rnd_idle cyc=%0d got_busy=%0b mr=%0b te=%0b exp=0", cyc, busy, m_ready, timeout_err); end
                        idle_next = 1'b1;
                    end
                end
                if (in_txn) begin
                    bcyc++;
                    checks++; if (s_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rnd_busy cyc=%0d got_sv=%0b busy=%0b exp=1", cyc, s_valid, busy); end
                    checks++; if (s_address !== ra[win] || s_wdata !== rw[win] || s_wstrb !== rs[win]) begin failures++; $display("FAIL rnd_s_req cyc=%0d got=%0h/%0h/%0h exp_master=%0d %0h/%0h/%0h", cyc, s_address, s_wdata, s_wstrb, win, ra[win], rw[win], rs[win]); end
                    checks++; if (m_ready !== '0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rnd_busy_quiet cyc=%0d got_mr=%0b te=%0b exp=0", cyc, m_ready, timeout_err); end
                    s_ready = ($urandom_range(0, 3) == 0);
                    s_rdata = $urandom;
                    if (s_ready) begin
                        exp_rd = s_rdata; exp_to = 1'b0; pend = 1'b1;
                    end else if (bcyc == TO) begin
                        exp_rd = '0; exp_to = 1'b1; pend = 1'b1;
                    end
                    idle_next = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom_range(0, 2) == 0)) begin
                    req[i] = 1'b1;
                    ra[i]  = $urandom;
                    rw[i]  = $urandom;
                    rs[i]  = 4'($urandom);
                end
            end
            m_valid   = req;
            m_address = {ra[1], ra[0]};
            m_wdata   = {rw[1], rw[0]};
            m_wstrb   = {rs[1], rs[0]};
            mv_prev   = req;
        end
        checks++; if (ncomp < 20) begin failures++; $display("FAIL rnd_completions got=%0d exp>=20", ncomp); end
        checks++; if (nto < 1) begin failures++; $display("FAIL rnd_timeouts_seen got=%0d exp>=1", nto); end
        m_valid = '0;
        s_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        m_valid   = '0;
        m_address = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        s_rdata   = '0;
        s_ready   = 1'b0;
        test_reset();
        test_fairness();
        test_single_read();
        test_timeout();
        test_write();
        test_late_ready();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
